// File: rtl/test_frame_scheduler_pkg.sv
// Shared definitions for the test frame scheduler: FSM states, header
// defaults and the frame-length bit-width helper.
package test_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam logic [15:0] ETH_TYPE_DEFAULT = 16'h88B5;
  localparam logic [47:0] MAC_DEFAULT      = 48'h02_00_00_00_00_00;

  // Number of low beat-counter bits that index a beat within one frame.
  function automatic int length_bits(input int length);
    return $clog2(length);
  endfunction

endpackage

// File: rtl/test_frame_scheduler.sv
// Test frame scheduler: emits a header followed by LENGTH payload beats per
// frame. The payload byte is a running beat counter that keeps counting
// across frames and runs, and is cleared only by reset. Frames can be
// separated by a programmable idle gap. A run ends after frame_num frames,
// or runs forever when frame_num is 0, and ends early on stop.
module test_frame_scheduler
  import test_frame_scheduler_pkg::*;
#(
  parameter int          LENGTH     = 512,
  parameter logic [47:0] LOCAL_MAC  = MAC_DEFAULT,
  parameter logic [47:0] DST_MAC    = MAC_DEFAULT,
  parameter logic [15:0] ETH_TYPE   = ETH_TYPE_DEFAULT,
  parameter int          DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           frame_num,
  input  logic [15:0]           gap_cycles,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frames_sent,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser
);

  localparam int            LB       = length_bits(LENGTH);
  localparam logic [LB-1:0] LAST_IDX = LB'(LENGTH - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] beat_cnt;
  logic [31:0] frame_num_lat;
  logic [15:0] gap_lat;
  logic [15:0] gap_cnt;
  logic        stop_pend;
  logic        stop_any;
  logic        pay_fire;
  logic        tlast_fire;
  logic        run_end;
  logic [31:0] frames_inc;

  assign stop_any   = stop | stop_pend;
  assign pay_fire   = (state == ST_PAYLOAD) && m_eth_payload_axis_tready;
  assign tlast_fire = pay_fire && (beat_cnt[LB-1:0] == LAST_IDX);
  assign frames_inc = frames_sent + 32'd1;
  assign run_end    = stop_any || ((frame_num_lat != 32'd0) && (frames_inc == frame_num_lat));

  // Valids and busy come straight from the state so an async reset drops them at once.
  assign busy                      = (state != ST_IDLE);
  assign m_eth_hdr_valid           = (state == ST_HDR);
  assign m_eth_dest_mac            = DST_MAC;
  assign m_eth_src_mac             = LOCAL_MAC;
  assign m_eth_type                = ETH_TYPE;
  assign m_eth_payload_axis_tvalid = (state == ST_PAYLOAD);
  assign m_eth_payload_axis_tdata  = beat_cnt[DATA_WIDTH-1:0];
  assign m_eth_payload_axis_tlast  = (beat_cnt[LB-1:0] == LAST_IDX);
  assign m_eth_payload_axis_tuser  = 1'b0;

  // Next-state decision; an accepted header always proceeds to its payload.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (start) state_next = ST_HDR;
      ST_HDR: begin
        if (m_eth_hdr_ready)  state_next = ST_PAYLOAD;
        else if (stop_any)    state_next = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (tlast_fire) begin
          if (run_end)                  state_next = ST_IDLE;
          else if (gap_lat == 16'd0)    state_next = ST_HDR;
          else                          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (stop_any)                   state_next = ST_IDLE;
        else if (gap_cnt == 16'd1)      state_next = ST_HDR;
      end
      default:                          state_next = ST_IDLE;
    endcase
  end

  // State register, done pulse on return to idle, and pending-stop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state != ST_IDLE) && (state_next == ST_IDLE);
      if (state_next == ST_IDLE)
        stop_pend <= 1'b0;
      else if (stop && (state != ST_IDLE))
        stop_pend <= 1'b1;
    end
  end

  // Running beat counter, advanced on every payload handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           beat_cnt <= 32'd0;
    else if (pay_fire) beat_cnt <= beat_cnt + 32'd1;
  end

  // Run configuration captured at start, plus the per-run frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_num_lat <= 32'd0;
      gap_lat       <= 16'd0;
      frames_sent   <= 32'd0;
    end else if ((state == ST_IDLE) && start) begin
      frame_num_lat <= frame_num;
      gap_lat       <= gap_cycles;
      frames_sent   <= 32'd0;
    end else if (tlast_fire) begin
      frames_sent   <= frames_inc;
    end
  end

  // Inter-frame gap down-counter, loaded as each frame's last beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  gap_cnt <= 16'd0;
    else if (tlast_fire)      gap_cnt <= gap_lat;
    else if (state == ST_GAP) gap_cnt <= gap_cnt - 16'd1;
  end

endmodule

// File: tb/tb_test_frame_scheduler.sv
// Bench for test_frame_scheduler: a stream-level model (expected byte
// sequence, frame boundaries, gap lengths, handshake rules) checked every
// cycle, plus directed runs with hand-computed end-of-run values.
module tb_test_frame_scheduler;

  // A frame length below 256 makes frame starts land on varied tdata values,
  // so continuity of the beat counter across runs is observable.
  localparam int LENGTH = 64;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] frame_num;
  logic [15:0] gap_cycles;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  test_frame_scheduler #(.LENGTH(LENGTH)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .stop                      (stop),
    .frame_num                 (frame_num),
    .gap_cycles                (gap_cycles),
    .busy                      (busy),
    .done                      (done),
    .frames_sent               (frames_sent),
    .m_eth_hdr_valid           (hdr_valid),
    .m_eth_hdr_ready           (hdr_ready),
    .m_eth_dest_mac            (dest_mac),
    .m_eth_src_mac             (src_mac),
    .m_eth_type                (eth_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser)
  );

  int checks   = 0;
  int failures = 0;
  int bp_mode  = 0;
  int cur_gap  = 0;

  // Model state, owned by the monitor process.
  logic [31:0] exp_beat = 32'd0;
  int  run_hdrs = 0, run_frames = 0, run_beats = 0, frame_beats = 0;
  int  idle_cnt = 0;
  bit  in_gap = 0;
  bit  prev_hdr_stall = 0, prev_t_stall = 0, prev_stop = 0;
  bit  prev_start_acc = 0, prev_hdr_fire = 0;
  logic [7:0] prev_tdata = 8'd0;
  logic       prev_tlast = 1'b0;

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle stream model and protocol checks.
  always @(negedge clk) begin
    if (rst) begin
      exp_beat = 32'd0;
      run_hdrs = 0; run_frames = 0; run_beats = 0; frame_beats = 0;
      in_gap = 0; idle_cnt = 0;
      prev_hdr_stall = 0; prev_t_stall = 0; prev_stop = 0;
      prev_start_acc = 0; prev_hdr_fire = 0;
    end else begin
      bit is_last;
      if (prev_start_acc) checkOutput("start_to_hdr_valid", hdr_valid, 1);
      if (prev_hdr_fire)  checkOutput("hdr_fire_to_tvalid", tvalid, 1);
      if (hdr_valid || tvalid) begin
        checkOutput("no_overlap", hdr_valid & tvalid, 0);
        checkOutput("busy_while_valid", busy, 1);
      end
      if (prev_hdr_stall && !prev_stop) checkOutput("hdr_valid_hold", hdr_valid, 1);
      if (prev_t_stall) begin
        checkOutput("tvalid_hold", tvalid, 1);
        checkOutput("tdata_hold", tdata, prev_tdata);
        checkOutput("tlast_hold", tlast, prev_tlast);
      end
      if (in_gap) begin
        if (hdr_valid) begin
          checkOutput("gap_length", idle_cnt, cur_gap);
          in_gap = 0;
        end else if (!busy) begin
          in_gap = 0;
        end else if (!tvalid) begin
          idle_cnt++;
        end
      end
      if (hdr_valid && hdr_ready) begin
        checkOutput("hdr_dest_mac", dest_mac, 48'h02_00_00_00_00_00);
        checkOutput("hdr_src_mac", src_mac, 48'h02_00_00_00_00_00);
        checkOutput("hdr_eth_type", eth_type, 16'h88B5);
        checkOutput("hdr_between_frames", frame_beats, 0);
        run_hdrs++;
      end
      if (tvalid && tready) begin
        is_last = ((exp_beat % LENGTH) == LENGTH - 1);
        checkOutput("tdata", tdata, exp_beat[7:0]);
        checkOutput("tlast", tlast, is_last);
        checkOutput("tuser", tuser, 0);
        checkOutput("one_hdr_per_frame", run_hdrs, run_frames + 1);
        exp_beat++; run_beats++; frame_beats++;
        if (is_last) begin
          run_frames++; frame_beats = 0; in_gap = 1; idle_cnt = 0;
        end
      end
      prev_start_acc = start && !busy;
      if (prev_start_acc) begin
        run_hdrs = 0; run_frames = 0; run_beats = 0;
      end
      prev_hdr_fire  = hdr_valid && hdr_ready;
      prev_hdr_stall = hdr_valid && !hdr_ready;
      prev_t_stall   = tvalid && !tready;
      prev_stop      = stop;
      prev_tdata     = tdata;
      prev_tlast     = tlast;
    end
  end

  // Backpressure driver: 0 = always ready, 1 = random, 2 = header held off.
  initial begin
    hdr_ready = 1'b1;
    tready    = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: begin
          hdr_ready = ($urandom_range(0, 3) != 0);
          tready    = ($urandom_range(0, 2) != 0);
        end
        2: begin hdr_ready = 1'b0; tready = 1'b1; end
        default: begin hdr_ready = 1'b1; tready = 1'b1; end
      endcase
    end
  end

  task automatic applyStimulus(input int frames, input int gap);
    frame_num  = 32'(frames);
    gap_cycles = 16'(gap);
    cur_gap    = gap;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input int exp_frames);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < max_cycles);
    checkOutput("done_seen", done, 1);
    checkOutput("frames_sent", frames_sent, exp_frames);
    checkOutput("model_frames", run_frames, exp_frames);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
  endtask

  initial begin
    int n;
    logic [31:0] saved;
    int frames;
    rst = 1'b1; start = 1'b0; stop = 1'b0; frame_num = 32'd0; gap_cycles = 16'd0;
    @(posedge clk); #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_hdr_valid", hdr_valid, 0);
    checkOutput("reset_tvalid", tvalid, 0);
    checkOutput("reset_frames_sent", frames_sent, 0);
    checkOutput("reset_tdata", tdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] run 1: two frames, no gap");
    bp_mode = 0;
    applyStimulus(2, 0);
    wait_done(400, 2);
    checkOutput("run1_beats", run_beats, 128);
    checkOutput("run1_hdrs", run_hdrs, 2);
    checkOutput("run1_model_beat", exp_beat, 128);

    $display("[TB] run 2: three frames, gap 5");
    applyStimulus(3, 5);
    wait_done(600, 3);
    checkOutput("run2_beats", run_beats, 192);
    checkOutput("run2_model_beat", exp_beat, 320);

    $display("[TB] run 3: random backpressure");
    bp_mode = 1;
    frames  = int'($urandom_range(2, 3));
    applyStimulus(frames, int'($urandom_range(0, 7)));
    wait_done(3000, frames);
    checkOutput("run3_beats", run_beats, frames * LENGTH);

    $display("[TB] run 4: continuous, stop mid frame 3");
    applyStimulus(0, 2);
    n = 0;
    while (!(run_frames == 2 && frame_beats == 40) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_frame3_beat40", frame_beats, 40);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(3000, 3);
    checkOutput("run4_frame_aligned", exp_beat % LENGTH, 0);
    bp_mode = 0;
    saved = exp_beat;
    applyStimulus(1, 0);
    n = 0;
    while (tvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resume_tdata", tdata, saved[7:0]);
    wait_done(300, 1);

    $display("[TB] run 5: stop while header is held off");
    bp_mode = 2;
    saved = exp_beat;
    applyStimulus(3, 0);
    repeat (2) @(posedge clk);
    #1 stop = 1'b1;
    @(negedge clk);
    checkOutput("hdr_valid_before_stop_edge", hdr_valid, 1);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    checkOutput("stop_hdr_done", done, 1);
    checkOutput("stop_hdr_valid_dropped", hdr_valid, 0);
    checkOutput("stop_hdr_idle", busy, 0);
    checkOutput("stop_hdr_frames_sent", frames_sent, 0);
    checkOutput("stop_hdr_no_beats", exp_beat, saved);
    @(negedge clk);
    checkOutput("stop_hdr_done_pulse", done, 0);

    $display("[TB] run 6: async reset mid payload");
    bp_mode = 0;
    applyStimulus(2, 0);
    n = 0;
    while (frame_beats != 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_beat20", frame_beats, 20);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_tvalid_low", tvalid, 0);
    checkOutput("rst_busy_low", busy, 0);
    checkOutput("rst_frames_sent", frames_sent, 0);
    checkOutput("rst_tdata_zero", tdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1, 0);
    wait_done(300, 1);
    checkOutput("after_rst_model_beat", exp_beat, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
